qpu_exu_timing_queue: RTL
=========================

# qpu_exu_timing_queue

- Timing queue directly downstream of the ALU's time (`twbck`) and event (`ewbck`) write-back ports.
- Holds the current timing point (TP), which is an absolute timestamp.
- Each accepted event is tagged with TP and buffered in a FIFO.
- A free-running system time counter releases each event as a one-cycle pulse toward the quantum control interface once the counter reaches the event's timestamp. The counter value is also exported as the `i_clk` source for dispatch.

## Interface
- `TW`, default `QPU_TIME_WIDTH`: timestamp and counter width.
- `EW`, default `QPU_EVENT_WIRE_WIDTH`: event payload width.
- `EN`, default `QPU_EVENT_NUM`: event operand mask width.
- `DEPTH`, default 8: FIFO entries; power of two, at least 2.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: leave IDLE or HALT and begin counting.
- `stop` in 1: freeze the counter (HALT).
- `twbck_i_valid` in 1, `twbck_i_ready` out 1, `twbck_i_data` in TW: new timing point.
- `ewbck_i_valid` in 1, `ewbck_i_ready` out 1: event write-back handshake.
- `ewbck_i_data` in EW, `ewbck_i_oprand` in EN: event payload and operand mask.
- `evt_o_valid` out 1: one-cycle release pulse; there is no backpressure.
- `evt_o_data` out EW, `evt_o_oprand` out EN: released event.
- `sys_time_o` out TW: system time counter.
- `tq_empty_o` out 1, `tq_full_o` out 1: FIFO status.
- `tq_late_o` out 1: sticky late-event flag (`QPU_TQ_LATE_CHK_EN` only).

## Operation
**States.** IDLE (reset state), RUN, HALT.
- IDLE→RUN on `start`.
- RUN→HALT on `stop`.
- HALT→RUN on `start`.
- `stop` has priority when asserted together with `start`.
- Counter increments by 1 only in RUN, wraps modulo 2^TW, and holds in IDLE and HALT.

**Write-back handshakes.**
- `twbck_i_ready` is tied to 1. On a `twbck` fire, TP ← `twbck_i_data`.
- `ewbck_i_ready` = ~full. On an `ewbck` fire, push {TP, data, oprand}.
- If `twbck` and `ewbck` fire in the same cycle, the event takes the new `twbck_i_data`, not the old TP. This is the same-instruction NTP+event case.

**Release.**
- Condition: state==RUN, FIFO non-empty, and `d = (sys_time - head_ts) mod 2^TW` has `d[TW-1]==0`. This means the head is due or past, using a wrap-aware window of 2^(TW-1).
- On release: pop, assert `evt_o_valid` with the head payload, at most one event per cycle.
- Events are released strictly in FIFO order. A later timestamp behind an earlier one waits.
- Push and pop in the same cycle while full: the pop frees a slot, but `ewbck_i_ready` is computed from the registered full flag and stays 0 for that cycle.
- Push into an empty FIFO: the entry becomes eligible for release from the next cycle.

**Reset mid-operation.** Flushes the FIFO, clears TP, counter and late flag, and returns to IDLE. No event is emitted during the cycle `rst` is asserted.

## Timing
- Reset values: `evt_o_valid`=0, `evt_o_data`=0, `evt_o_oprand`=0, `sys_time_o`=0, `tq_empty_o`=1, `tq_full_o`=0, `tq_late_o`=0, `ewbck_i_ready`=1, `twbck_i_ready`=1.
- Release outputs are registered. An event is due at the rising edge where `sys_time` first satisfies the release condition; `evt_o_valid` is high in the following cycle.
- Minimum push-to-release latency is 2 cycles (for a timestamp already due).
- An event with `ts == sys_time + k` pulses k+1 cycles after `sys_time_o` shows the current value, assuming RUN is continuous.
- `sys_time_o` is registered. `tq_full_o`/`tq_empty_o` are registered and update the cycle after push/pop.

## Configuration
`QPU_TQ_LATE_CHK_EN`:
- **Defined:** at release, if `d != 0`, `tq_late_o` sets and stays set until `rst`. The event is still released.
- **Undefined:** no late-check logic; `tq_late_o` is tied to 0.

## Structure
- Add to `QPU_defines.v`:
  - `QPU_TQ_DEPTH`
  - state encodings `QPU_TQ_ST_IDLE`/`RUN`/`HALT` (2 bits)
  - `QPU_TQ_ENTRY_WIDTH` = TW+EW+EN
- One sub-module: `qpu_tq_fifo`, a synchronous FIFO (`DEPTH`, entry width) providing push, pop, head, full and empty, with pointers one bit wider than the index.
- The top level holds the FSM, TP register, counter, release compare and late flag.

## Test plan
- Reset, `start`, push event (data=0x5, oprand=0x1) with TP=0 → `evt_o_valid` pulses 2 cycles after push with data 0x5 and oprand 0x1; `tq_late_o`=1 because the push occurs after sys_time has already passed 0.
- `twbck`=100, then event A, then `twbck`=90, then event B → A is released when sys_time reaches 100. B is released right after A, and `tq_late_o`=1 (late flag enabled).
- Same-cycle `twbck`=50 and `ewbck` → event is tagged 50 and pulses exactly once, in the cycle after sys_time==50.
- Push `DEPTH` events with ts=1000 in IDLE → `tq_full_o`=1, `ewbck_i_ready`=0, further push is held. After `start`, all `DEPTH` events release on consecutive cycles starting at time 1000.
- TW=8: counter at 250, event ts=3 → no release until the counter wraps; pulse at time 3, `tq_late_o`=0.
- `stop` during RUN with a pending event due at +5 → counter freezes and no pulse occurs. `start` resumes, and the pulse occurs 5 counts later. A `rst` while HALT is asserted clears the FIFO, and no pulse is ever emitted.

Source files
------------

// File: rtl/qpu_exu_timing_queue_pkg.sv
// Shared widths, depth and state encodings for the EXU timing queue.
package qpu_exu_timing_queue_pkg;

  localparam int unsigned QPU_TIME_WIDTH       = 32;
  localparam int unsigned QPU_EVENT_WIRE_WIDTH = 8;
  localparam int unsigned QPU_EVENT_NUM        = 4;
  localparam int unsigned QPU_TQ_DEPTH         = 8;
  localparam int unsigned QPU_TQ_ENTRY_WIDTH   =
    QPU_TIME_WIDTH + QPU_EVENT_WIRE_WIDTH + QPU_EVENT_NUM;

  typedef enum logic [1:0] {
    QPU_TQ_ST_IDLE = 2'd0,
    QPU_TQ_ST_RUN  = 2'd1,
    QPU_TQ_ST_HALT = 2'd2
  } tq_state_e;

endpackage

// File: rtl/qpu_tq_fifo.sv
// Synchronous FIFO for timing-queue entries; pointers carry one extra wrap bit.
module qpu_tq_fifo
  import qpu_exu_timing_queue_pkg::*;
#(
  parameter int unsigned DEPTH = QPU_TQ_DEPTH,
  parameter int unsigned WIDTH = QPU_TQ_ENTRY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i & ~full_q;
  assign pop_ok  = pop_i & ~empty_q;

  // Status flags are computed from next pointers so they are registered.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/qpu_exu_timing_queue.sv
// Timestamps ALU events with the current timing point and releases them when system time is due.
// Optional QPU_TQ_LATE_CHK_EN adds a sticky flag for events released after their timestamp.
module qpu_exu_timing_queue
  import qpu_exu_timing_queue_pkg::*;
#(
  parameter int unsigned TW    = QPU_TIME_WIDTH,
  parameter int unsigned EW    = QPU_EVENT_WIRE_WIDTH,
  parameter int unsigned EN    = QPU_EVENT_NUM,
  parameter int unsigned DEPTH = QPU_TQ_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          twbck_i_valid,
  output logic          twbck_i_ready,
  input  logic [TW-1:0] twbck_i_data,
  input  logic          ewbck_i_valid,
  output logic          ewbck_i_ready,
  input  logic [EW-1:0] ewbck_i_data,
  input  logic [EN-1:0] ewbck_i_oprand,
  output logic          evt_o_valid,
  output logic [EW-1:0] evt_o_data,
  output logic [EN-1:0] evt_o_oprand,
  output logic [TW-1:0] sys_time_o,
  output logic          tq_empty_o,
  output logic          tq_full_o,
  output logic          tq_late_o
);

  localparam int unsigned ENTRY_W = TW + EW + EN;

  tq_state_e      state_q;
  logic [TW-1:0]  tp_q;
  logic [TW-1:0]  sys_time_q;
  logic           evt_valid_q;
  logic [EW-1:0]  evt_data_q;
  logic [EN-1:0]  evt_opr_q;

  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic [TW-1:0]      push_ts, head_ts, diff;
  logic [EW-1:0]      head_data;
  logic [EN-1:0]      head_opr;
  logic               ew_fire, release_c;

  // A same-cycle timing point write applies to the event being pushed.
  assign push_ts    = twbck_i_valid ? twbck_i_data : tp_q;
  assign push_entry = {push_ts, ewbck_i_data, ewbck_i_oprand};
  assign {head_ts, head_data, head_opr} = head_entry;

  assign twbck_i_ready = 1'b1;
  assign ewbck_i_ready = ~fifo_full;
  assign ew_fire       = ewbck_i_valid & ~fifo_full;

  // Head is due when it lies in the half-range window at or behind system time.
  assign diff      = sys_time_q - head_ts;
  assign release_c = (state_q == QPU_TQ_ST_RUN) && !fifo_empty && !diff[TW-1];

  qpu_tq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ew_fire),
    .pop_i   (release_c),
    .data_i  (push_entry),
    .head_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= QPU_TQ_ST_IDLE;
      tp_q        <= '0;
      sys_time_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      evt_opr_q   <= '0;
    end else begin
      unique case (state_q)
        QPU_TQ_ST_IDLE: if (start && !stop) state_q <= QPU_TQ_ST_RUN;
        QPU_TQ_ST_RUN:  if (stop)           state_q <= QPU_TQ_ST_HALT;
        QPU_TQ_ST_HALT: if (start && !stop) state_q <= QPU_TQ_ST_RUN;
        default:                            state_q <= QPU_TQ_ST_IDLE;
      endcase
      if (state_q == QPU_TQ_ST_RUN) sys_time_q <= sys_time_q + TW'(1);
      if (twbck_i_valid) tp_q <= twbck_i_data;
      evt_valid_q <= release_c;
      if (release_c) begin
        evt_data_q <= head_data;
        evt_opr_q  <= head_opr;
      end
    end
  end

`ifdef QPU_TQ_LATE_CHK_EN
  logic late_q;

  always_ff @(posedge clk) begin
    if (rst)                              late_q <= 1'b0;
    else if (release_c && (diff != '0))   late_q <= 1'b1;
  end

  assign tq_late_o = late_q;
`else
  assign tq_late_o = 1'b0;
`endif

  assign evt_o_valid  = evt_valid_q;
  assign evt_o_data   = evt_data_q;
  assign evt_o_oprand = evt_opr_q;
  assign sys_time_o   = sys_time_q;
  assign tq_empty_o   = fifo_empty;
  assign tq_full_o    = fifo_full;

endmodule
